seq_compare_unit: RTL
=====================

// Module: seq_compare_unit
// PURPOSE
//   Parametrised multi-cycle set-less-than unit for the pipelined core's SLT/SLTU path.
//   Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and stops on the first differing chunk.
//   Supports signed (SLT) and unsigned (SLTU) modes.
//   Uses a valid/ready handshake on both input and output, so the execute stage can stall on it.
// PARAMETERS
//   WIDTH  64  operand and result width; must be a multiple of CHUNK
//   CHUNK  8   bits compared per cycle; NCHUNK = WIDTH/CHUNK (default 8)
// PORTS
//   clk          in   1      single clock; all state updates on its rising edge
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      rs1, rs2 and is_unsigned are valid
//   in_ready     out  1      unit can accept an operation
//   rs1          in   WIDTH  first operand
//   rs2          in   WIDTH  second operand
//   is_unsigned  in   1      1 = SLTU semantics, 0 = SLT semantics
//   out_valid    out  1      result, lt and eq are valid
//   out_ready    in   1      consumer accepts the result
//   result       out  WIDTH  {WIDTH-1 zeros, lt}
//   lt           out  1      rs1 < rs2 in the selected mode
//   eq           out  1      rs1 == rs2
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst=1 at a clock edge):
//     - state -> IDLE; out_valid, result, lt, eq and busy -> 0; in_ready -> 1.
//     - An operation in flight is discarded and no result is produced for it.
//     - rst takes priority over every other event in the same cycle.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid & in_ready, latch rs1, rs2 and the mode; chunk index <- NCHUNK-1 (MSB chunk); go to RUN.
//   Signed mode:
//     - Invert bit WIDTH-1 of both latched operands; then compare as unsigned.
//     - Unsigned mode compares the operands unchanged.
//   RUN (in_ready=0), one chunk per cycle:
//     - Chunk differs: lt <- (a_chunk < b_chunk); eq <- 0; go to DONE.
//     - Chunk equal and index != 0: decrement index; stay in RUN.
//     - Chunk equal and index == 0: lt <- 0; eq <- 1; go to DONE.
//   DONE:
//     - out_valid=1; result, lt and eq are held stable while out_ready=0.
//     - On out_ready=1, go to IDLE. out_valid and in_ready update at that edge.
//     - No new operation is accepted in the same cycle as the result handshake.
//   Latency: accept at edge N -> out_valid high from cycle N+j.
//     - j = 1-based position, from MSB, of the first differing chunk.
//     - j = NCHUNK when the operands are equal.
//     - Range 1..NCHUNK.
//   in_valid while in_ready=0 is ignored; the source must hold its request until accepted.
//   After the result handshake, result, lt and eq keep their last values; only out_valid drops.
//   Operands are latched at accept; input changes during RUN/DONE have no effect.
// TESTING
//   1. Signed, rs1=-15, rs2=16 -> lt=1, eq=0, result=1; out_valid 1 cycle after accept.
//   2. Unsigned, rs1=-15 (0xFFFF_FFFF_FFFF_FFF1), rs2=16 -> lt=0, eq=0; latency 1.
//   3. rs1=rs2=-15, both modes -> lt=0, eq=1; latency 8 (NCHUNK).
//   4. rs1=0, rs2=64'h8000_0000_0000_0000:
//      signed -> lt=0; unsigned -> lt=1; both with latency 1.
//   5. rs1=1, rs2=2, signed -> lt=1, latency 8.
//      Hold out_ready=0 for 5 cycles: outputs stay stable.
//      Pulse in_valid during that time: the request is not accepted.
//   6. Assert rst in the 3rd RUN cycle of an equal-operand op:
//      next cycle state is IDLE, out_valid=0 and in_ready=1; a new op then completes correctly.
//   Also rerun 1-5 with WIDTH=32, CHUNK=4 and check the latency bounds scale (max 8).

Source files
------------

// File: rtl/seq_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_compare_unit
// Description : Multi-cycle SLT/SLTU unit, compares CHUNK bits per cycle from
//               the MSB end and stops at the first differing chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_compare_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] w_a_chunk [NCHUNK];
    logic [CHUNK-1:0] w_b_chunk [NCHUNK];
    logic [CHUNK-1:0] w_cur_a;
    logic [CHUNK-1:0] w_cur_b;

    generate
        for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
            assign w_a_chunk[i] = a_q[i*CHUNK +: CHUNK];
            assign w_b_chunk[i] = b_q[i*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_cur_a = w_a_chunk[idx_q];
    assign w_cur_b = w_b_chunk[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d     = rs1 ^ (is_unsigned ? '0 : SIGN_MASK);
                    b_d     = rs2 ^ (is_unsigned ? '0 : SIGN_MASK);
                    idx_d   = IDX_TOP;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_cur_a != w_cur_b) begin
                    lt_d    = (w_cur_a < w_cur_b);
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        lt        = lt_q;
        eq        = eq_q;
        result    = {{(WIDTH-1){1'b0}}, lt_q};
    end

endmodule
`default_nettype wire
